// File: rtl/ext_mem_pkg.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | ext_mem_pkg                                                          |
// | Shared types and helpers for the external memory responder.         |
// | Rev 1.0                                                              |
// +----------------------------------------------------------------------+
package ext_mem_pkg;

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    RD_WAIT = 2'd1,
    WR_WAIT = 2'd2
  } chan_state_t;

  localparam int c_max_data_w = 32;

  // Counter must hold (max delay - 2); never narrower than one bit.
  function automatic int delay_width(input int rd_delay, input int wr_delay);
    int m;
    m = (rd_delay > wr_delay) ? rd_delay : wr_delay;
    return (m > 1) ? $clog2(m) : 1;
  endfunction

  function automatic logic [c_max_data_w-1:0] size_mask(input int size, input int width);
    logic [c_max_data_w-1:0] m;
    m = '0;
    for (int i = 0; i < c_max_data_w; i++) begin
      m[i] = (i < size) && (i < width);
    end
    return m;
  endfunction

endpackage
`default_nettype wire

// File: rtl/ext_mem_channel_fsm.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | ext_mem_channel_fsm                                                  |
// | Per-channel request decode, delay counter and completion pulse.     |
// | Rev 1.0                                                              |
// +----------------------------------------------------------------------+
module ext_mem_channel_fsm
  import ext_mem_pkg::*;
#(
  parameter int READ_DELAY  = 2,
  parameter int WRITE_DELAY = 1
) (
  input  logic clock,
  input  logic reset,
  input  logic oe,
  input  logic we,
  input  logic in_range,
  output logic rd_start,
  output logic rd_done,
  output logic wr_done,
  output logic idle
);

  localparam int c_dly_w = delay_width(READ_DELAY, WRITE_DELAY);
  localparam logic [c_dly_w-1:0] c_rd_load = c_dly_w'((READ_DELAY > 1) ? READ_DELAY - 2 : 0);
  localparam logic [c_dly_w-1:0] c_wr_load = c_dly_w'((WRITE_DELAY > 1) ? WRITE_DELAY - 2 : 0);

  chan_state_t        r_state;
  logic [c_dly_w-1:0] r_cnt;
  logic               w_rd_req;
  logic               w_wr_req;

  assign w_rd_req = oe & ~we & in_range;
  assign w_wr_req = we & ~oe & in_range;

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      r_state <= IDLE;
      r_cnt   <= '0;
    end else begin
      case (r_state)
        IDLE: begin
          if (w_rd_req && (READ_DELAY > 1)) begin
            r_state <= RD_WAIT;
            r_cnt   <= c_rd_load;
          end else if (w_wr_req && (WRITE_DELAY > 1)) begin
            r_state <= WR_WAIT;
            r_cnt   <= c_wr_load;
          end
        end
        // A dropped request aborts the access without a pulse.
        RD_WAIT: begin
          if (!w_rd_req || r_cnt == '0) r_state <= IDLE;
          else                          r_cnt   <= r_cnt - 1'b1;
        end
        WR_WAIT: begin
          if (!w_wr_req || r_cnt == '0) r_state <= IDLE;
          else                          r_cnt   <= r_cnt - 1'b1;
        end
        default: r_state <= IDLE;
      endcase
    end
  end

  assign idle     = (r_state == IDLE);
  assign rd_start = ~reset & idle & w_rd_req;
  assign rd_done  = ~reset & w_rd_req &
                    ((idle & (READ_DELAY == 1)) | ((r_state == RD_WAIT) & (r_cnt == '0)));
  assign wr_done  = ~reset & w_wr_req &
                    ((idle & (WRITE_DELAY == 1)) | ((r_state == WR_WAIT) & (r_cnt == '0)));

endmodule
`default_nettype wire

// File: rtl/ext_mem_responder.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | ext_mem_responder                                                    |
// | Byte-addressed memory answering the multi-channel master bus.       |
// | Rev 1.0                                                              |
// +----------------------------------------------------------------------+
module ext_mem_responder
  import ext_mem_pkg::*;
#(
  parameter int CHANNELS    = 2,
  parameter int ADDR_W      = 8,
  parameter int DATA_W      = 8,
  parameter int SIZE_W      = 4,
  parameter int MEM_BYTES   = 256,
  parameter int BASE_ADDR   = 0,
  parameter int READ_DELAY  = 2,
  parameter int WRITE_DELAY = 1
) (
  input  logic                         clock,
  input  logic                         reset,
  input  logic                         preload_valid,
  output logic                         preload_ready,
  input  logic [ADDR_W-1:0]            preload_addr,
  input  logic [DATA_W-1:0]            preload_data,
  input  logic [CHANNELS-1:0]          Mout_oe_ram,
  input  logic [CHANNELS-1:0]          Mout_we_ram,
  input  logic [CHANNELS*ADDR_W-1:0]   Mout_addr_ram,
  input  logic [CHANNELS*DATA_W-1:0]   Mout_Wdata_ram,
  input  logic [CHANNELS*SIZE_W-1:0]   Mout_data_ram_size,
  output logic [CHANNELS*DATA_W-1:0]   M_Rdata_ram,
  output logic [CHANNELS-1:0]          M_DataRdy,
  output logic [1:0]                   err_flags
);

  localparam int c_idx_w = (MEM_BYTES > 1) ? $clog2(MEM_BYTES) : 1;

  logic [DATA_W-1:0]   r_mem [MEM_BYTES];
  logic [DATA_W-1:0]   w_wr_val [CHANNELS];
  logic [c_idx_w-1:0]  w_idx [CHANNELS];
  logic [CHANNELS-1:0] w_in_range;
  logic [CHANNELS-1:0] w_rd_start;
  logic [CHANNELS-1:0] w_rd_done;
  logic [CHANNELS-1:0] w_wr_done;
  logic [CHANNELS-1:0] w_idle;
  logic                w_preload_hit;
  logic [1:0]          r_err;

  for (genvar g = 0; g < CHANNELS; g++) begin : g_chan
    logic [ADDR_W-1:0] w_addr;
    logic [DATA_W-1:0] w_wdata;
    logic [SIZE_W-1:0] w_size;
    logic [DATA_W-1:0] w_mask;
    logic [DATA_W-1:0] w_cur;
    logic [DATA_W-1:0] r_rdata;

    assign w_addr  = Mout_addr_ram[g*ADDR_W +: ADDR_W];
    assign w_wdata = Mout_Wdata_ram[g*DATA_W +: DATA_W];
    assign w_size  = Mout_data_ram_size[g*SIZE_W +: SIZE_W];

    assign w_in_range[g] = (32'(w_addr) >= 32'(BASE_ADDR)) &&
                           (32'(w_addr) <  32'(BASE_ADDR + MEM_BYTES));
    assign w_idx[g]      = c_idx_w'(32'(w_addr) - 32'(BASE_ADDR));
    assign w_mask        = DATA_W'(size_mask(int'(w_size), DATA_W));
    assign w_cur         = r_mem[w_idx[g]] & w_mask;
    assign w_wr_val[g]   = (w_wdata & w_mask) | (r_mem[w_idx[g]] & ~w_mask);

    ext_mem_channel_fsm #(
      .READ_DELAY  (READ_DELAY),
      .WRITE_DELAY (WRITE_DELAY)
    ) u_fsm (
      .clock    (clock),
      .reset    (reset),
      .oe       (Mout_oe_ram[g]),
      .we       (Mout_we_ram[g]),
      .in_range (w_in_range[g]),
      .rd_start (w_rd_start[g]),
      .rd_done  (w_rd_done[g]),
      .wr_done  (w_wr_done[g]),
      .idle     (w_idle[g])
    );

    // Read data is captured in the request cycle, before any same-edge write.
    always_ff @(posedge clock or posedge reset) begin
      if (reset)              r_rdata <= '0;
      else if (w_rd_start[g]) r_rdata <= w_cur;
    end

    assign M_Rdata_ram[g*DATA_W +: DATA_W] =
      w_rd_done[g] ? ((READ_DELAY == 1) ? w_cur : r_rdata) : '0;
    assign M_DataRdy[g] = w_rd_done[g] | w_wr_done[g];
  end

  assign preload_ready = preload_valid & (&w_idle) &
                         ~(|(Mout_oe_ram | Mout_we_ram)) & ~reset;
  assign w_preload_hit = preload_ready && (32'(preload_addr) < 32'(MEM_BYTES));

  // Later assignments win: higher channel numbers override lower ones.
  always_ff @(posedge clock) begin
    if (w_preload_hit) r_mem[c_idx_w'(preload_addr)] <= preload_data;
    for (int c = 0; c < CHANNELS; c++) begin
      if (w_wr_done[c]) r_mem[w_idx[c]] <= w_wr_val[c];
    end
  end

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      r_err <= '0;
    end else begin
      if (|(Mout_oe_ram & Mout_we_ram))                   r_err[0] <= 1'b1;
      if (|((Mout_oe_ram | Mout_we_ram) & ~w_in_range))   r_err[1] <= 1'b1;
    end
  end

  assign err_flags = r_err;

endmodule
`default_nettype wire

// File: tb/tb_ext_mem_responder.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | tb_ext_mem_responder                                                 |
// | Directed and randomized checks against a byte-array reference model.|
// | Rev 1.0                                                              |
// +----------------------------------------------------------------------+
module tb_ext_mem_responder;

  localparam int c_mem   = 16;
  localparam int c_rd_dl = 2;
  localparam int c_wr_dl = 1;
  localparam int c_maxw  = 20;

  logic        clock = 1'b0;
  logic        reset = 1'b1;
  logic        preload_valid = 1'b0;
  logic        preload_ready;
  logic [7:0]  preload_addr = '0;
  logic [7:0]  preload_data = '0;
  logic [1:0]  Mout_oe_ram = '0;
  logic [1:0]  Mout_we_ram = '0;
  logic [15:0] Mout_addr_ram = '0;
  logic [15:0] Mout_Wdata_ram = '0;
  logic [7:0]  Mout_data_ram_size = '0;
  logic [15:0] M_Rdata_ram;
  logic [1:0]  M_DataRdy;
  logic [1:0]  err_flags;

  int tests = 0;
  int fails = 0;
  int model [c_mem];

  ext_mem_responder #(
    .CHANNELS(2), .ADDR_W(8), .DATA_W(8), .SIZE_W(4), .MEM_BYTES(c_mem),
    .BASE_ADDR(0), .READ_DELAY(c_rd_dl), .WRITE_DELAY(c_wr_dl)
  ) dut (
    .clock              (clock),
    .reset              (reset),
    .preload_valid      (preload_valid),
    .preload_ready      (preload_ready),
    .preload_addr       (preload_addr),
    .preload_data       (preload_data),
    .Mout_oe_ram        (Mout_oe_ram),
    .Mout_we_ram        (Mout_we_ram),
    .Mout_addr_ram      (Mout_addr_ram),
    .Mout_Wdata_ram     (Mout_Wdata_ram),
    .Mout_data_ram_size (Mout_data_ram_size),
    .M_Rdata_ram        (M_Rdata_ram),
    .M_DataRdy          (M_DataRdy),
    .err_flags          (err_flags)
  );

  always #5 clock = ~clock;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    tests++;
    assert (obs === exp) else begin
      fails++;
      $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
    end
  endtask

  function automatic int mask_of(input int sz);
    return (sz >= 8) ? 255 : (1 << sz) - 1;
  endfunction

  task automatic preload(input logic [7:0] a, input logic [7:0] d);
    preload_valid = 1'b1; preload_addr = a; preload_data = d;
    @(negedge clock);
    check("preload_ready", 32'(preload_ready), 32'd1);
    @(posedge clock); #1;
    preload_valid = 1'b0;
    if (a < c_mem) model[a] = d;
  endtask

  task automatic bus_access(input int ch, input bit wr, input logic [7:0] a,
                            input logic [7:0] d, input logic [3:0] sz,
                            output int lat, output logic [7:0] rd);
    lat = -1; rd = '0;
    Mout_oe_ram[ch] = !wr; Mout_we_ram[ch] = wr;
    Mout_addr_ram[ch*8 +: 8] = a; Mout_Wdata_ram[ch*8 +: 8] = d;
    Mout_data_ram_size[ch*4 +: 4] = sz;
    for (int c = 0; c < c_maxw; c++) begin
      @(negedge clock);
      if (M_DataRdy[ch]) begin
        lat = c; rd = M_Rdata_ram[ch*8 +: 8];
        break;
      end
      @(posedge clock); #1;
    end
    if (lat >= 0) begin @(posedge clock); #1; end
    Mout_oe_ram[ch] = 1'b0; Mout_we_ram[ch] = 1'b0;
  endtask

  initial begin
    int lat, ch, a, sz, d, exp_v, rdy_seen;
    logic [7:0] rd;
    bit wr;

    // Reset state
    repeat (3) @(posedge clock);
    @(negedge clock);
    check("reset_rdy", 32'(M_DataRdy), 32'd0);
    check("reset_rdata", 32'(M_Rdata_ram), 32'd0);
    check("reset_err", 32'(err_flags), 32'd0);
    check("reset_pready", 32'(preload_ready), 32'd0);
    @(posedge clock); #1 reset = 1'b0;

    for (int i = 0; i < c_mem; i++) preload(8'(i), 8'($urandom_range(0, 255)));
    preload(8'd3, 8'hA5);
    preload(8'd5, 8'hFF);
    // Out-of-range preload must not alias onto a valid index
    preload(8'd20, 8'h77);

    bus_access(0, 1'b0, 8'd3, 8'h00, 4'd8, lat, rd);
    check("rd3_lat", 32'(lat), 32'(c_rd_dl - 1));
    check("rd3_data", 32'(rd), 32'hA5);

    bus_access(0, 1'b0, 8'd4, 8'h00, 4'd8, lat, rd);
    check("rd4_after_oob_preload", 32'(rd), 32'(model[4]));

    bus_access(1, 1'b1, 8'd5, 8'h3C, 4'd4, lat, rd);
    check("wr5_lat", 32'(lat), 32'(c_wr_dl - 1));
    model[5] = (8'h3C & mask_of(4)) | (model[5] & ~mask_of(4) & 255);
    bus_access(0, 1'b0, 8'd5, 8'h00, 4'd8, lat, rd);
    check("rd5_merge", 32'(rd), 32'hFC);

    // Both channels write index 7 in the same cycle
    Mout_we_ram = 2'b11;
    Mout_addr_ram = {8'd7, 8'd7};
    Mout_Wdata_ram = {8'h22, 8'h11};
    Mout_data_ram_size = {4'd8, 4'd8};
    @(negedge clock);
    check("dual_wr_rdy", 32'(M_DataRdy), 32'h3);
    @(posedge clock); #1 Mout_we_ram = 2'b00;
    model[7] = 8'h22;
    bus_access(0, 1'b0, 8'd7, 8'h00, 4'd8, lat, rd);
    check("dual_rd_ch0", 32'(rd), 32'h22);
    bus_access(1, 1'b0, 8'd7, 8'h00, 4'd8, lat, rd);
    check("dual_rd_ch1", 32'(rd), 32'h22);

    // Read on ch0 and write on ch1 to index 6 in the same cycle
    exp_v = model[6];
    Mout_oe_ram = 2'b01; Mout_we_ram = 2'b10;
    Mout_addr_ram = {8'd6, 8'd6};
    Mout_Wdata_ram = {8'h5C, 8'h00};
    @(negedge clock);
    check("rw_same_rdy_n", 32'(M_DataRdy), 32'h2);
    @(posedge clock); #1 Mout_we_ram = 2'b00;
    model[6] = 8'h5C;
    @(negedge clock);
    check("rw_same_rdy_n1", 32'(M_DataRdy), 32'h1);
    check("rw_same_old", 32'(M_Rdata_ram[7:0]), 32'(exp_v));
    @(posedge clock); #1 Mout_oe_ram = 2'b00;

    // Randomized accesses against the reference model
    for (int n = 0; n < 40; n++) begin
      ch = $urandom_range(0, 1);
      wr = 1'($urandom_range(0, 1));
      a  = $urandom_range(0, c_mem - 1);
      sz = $urandom_range(0, 15);
      d  = $urandom_range(0, 255);
      bus_access(ch, wr, 8'(a), 8'(d), 4'(sz), lat, rd);
      if (wr) begin
        check("rand_wr_lat", 32'(lat), 32'(c_wr_dl - 1));
        model[a] = (d & mask_of(sz)) | (model[a] & (255 - mask_of(sz)));
      end else begin
        check("rand_rd_lat", 32'(lat), 32'(c_rd_dl - 1));
        check("rand_rd_data", 32'(rd), 32'(model[a] & mask_of(sz)));
      end
    end
    check("err_clean", 32'(err_flags), 32'd0);

    // Out-of-range read: never completes, flags range error
    rdy_seen = 0;
    Mout_oe_ram = 2'b01; Mout_addr_ram[7:0] = 8'hFF; Mout_data_ram_size[3:0] = 4'd8;
    for (int c = 0; c < 10; c++) begin
      @(negedge clock);
      if (M_DataRdy != 2'b00) rdy_seen++;
      @(posedge clock); #1;
    end
    Mout_oe_ram = 2'b00;
    check("oob_no_rdy", 32'(rdy_seen), 32'd0);
    check("oob_err", 32'(err_flags), 32'h2);

    // Reset in the middle of a read
    Mout_oe_ram = 2'b01; Mout_addr_ram[7:0] = 8'd2;
    @(posedge clock); #1 reset = 1'b1;
    @(negedge clock);
    check("rst_mid_rdy", 32'(M_DataRdy), 32'd0);
    check("rst_mid_rdata", 32'(M_Rdata_ram), 32'd0);
    check("rst_mid_err", 32'(err_flags), 32'd0);
    Mout_oe_ram = 2'b00;
    @(posedge clock); #1 reset = 1'b0;
    rdy_seen = 0;
    for (int c = 0; c < 3; c++) begin
      @(negedge clock);
      if (M_DataRdy != 2'b00) rdy_seen++;
    end
    check("rst_after_rdy", 32'(rdy_seen), 32'd0);
    @(posedge clock); #1;
    bus_access(0, 1'b0, 8'd2, 8'h00, 4'd8, lat, rd);
    check("rst_byte_kept", 32'(rd), 32'(model[2]));

    // Preload blocked while ch0 has a read in flight
    Mout_oe_ram = 2'b01; Mout_addr_ram[7:0] = 8'd4; Mout_data_ram_size[3:0] = 4'd8;
    preload_valid = 1'b1; preload_addr = 8'd9; preload_data = 8'h5A;
    @(negedge clock);
    check("pl_block_n", 32'(preload_ready), 32'd0);
    @(posedge clock); #1;
    @(negedge clock);
    check("pl_block_rdy", 32'(M_DataRdy), 32'h1);
    check("pl_block_n1", 32'(preload_ready), 32'd0);
    @(posedge clock); #1 Mout_oe_ram = 2'b00;
    @(negedge clock);
    check("pl_accept", 32'(preload_ready), 32'd1);
    @(posedge clock); #1 preload_valid = 1'b0;
    model[9] = 8'h5A;
    bus_access(1, 1'b0, 8'd9, 8'h00, 4'd8, lat, rd);
    check("pl_readback", 32'(rd), 32'h5A);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
`default_nettype wire
